// File: rtl/if_fetch_unit.sv
// if_fetch_unit
//   Instruction-fetch stage. Owns the fetch PC and issues in-order word
//   requests to instruction memory. Returned words are buffered in a small
//   FIFO together with their PC and handed to ID over a valid/ready handshake.
//   A redirect from EX (pc_src/new_pc) flushes the buffer, marks every
//   in-flight response for discard, and restarts fetch at the target.
//
// Ports
//   clk, rstn                       clock (rising edge), async active-low reset
//   fetch_en                        1 = keep issuing requests
//   pc_src, new_pc                  redirect strobe and target from EX
//   imem_req, imem_addr             request to instruction memory
//   imem_ready                      memory accepts the request this cycle
//   imem_rvalid, imem_rdata         in-order response, one per accepted request
//   if_valid, if_inst, if_pc        FIFO head presented to ID
//   id_ready                        ID consumes the head this cycle
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fetch_en,
  input  logic        pc_src,
  input  logic [31:0] new_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        id_ready
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   target_pc;
  logic [31:0]   fifo_inst [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] discard;
  logic [CW:0]   in_flight;
  logic          credit_ok;
  logic          fifo_empty;
  logic          fifo_full;
  logic          accept;
  logic          push;
  logic          pop;

  assign target_pc  = new_pc & 32'hFFFF_FFFC;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));

  // Buffered words plus requests still in flight may never exceed the FIFO
  // depth, so every response is guaranteed a slot when it lands.
  assign in_flight = {1'b0, fifo_count} + {1'b0, outstanding};
  assign credit_ok = (in_flight < (CW + 1)'(FIFO_DEPTH));

  assign accept = imem_req & imem_ready;
  assign pop    = if_valid & id_ready;
  // A response arriving in the redirect cycle is wrong-path and dropped.
  assign push   = imem_rvalid & ~pc_src & (discard == '0);

  assign outstanding_next = outstanding + CW'(accept) - CW'(imem_rvalid);

  assign imem_addr = fetch_pc;
  assign if_inst   = fifo_inst[rd_ptr];
  assign if_pc     = fifo_pc[rd_ptr];

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= BOOT;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      BOOT:    state_next = RUN;
      RUN:     state_next = fetch_en ? RUN : STOP;
      STOP:    state_next = fetch_en ? RUN : STOP;
      default: state_next = BOOT;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req = (state == RUN) & ~pc_src & credit_ok;
    if_valid = ~fifo_empty & ~pc_src;
  end

  // Datapath: PCs, FIFO and in-flight bookkeeping
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      discard     <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_inst[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else begin
      outstanding <= outstanding_next;
      if (pc_src) begin
        // Everything still outstanding after this edge belongs to the old
        // path; those responses are counted off as they return.
        fetch_pc   <= target_pc;
        resp_pc    <= target_pc;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        discard    <= outstanding_next;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          fifo_inst[wr_ptr] <= imem_rdata;
          fifo_pc[wr_ptr]   <= resp_pc;
          wr_ptr            <= wr_ptr + 1'b1;
          resp_pc           <= resp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
        if (imem_rvalid && (discard != '0)) discard <= discard - 1'b1;
      end
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rstn) !(push && fifo_full));

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit
//   Randomized bench for if_fetch_unit. A transaction-level reference model
//   (queues of buffered instructions and of in-flight requests, each carrying
//   a "wrong path" flag) predicts the request and ID-side outputs every cycle.
//   A bench-side memory answers accepted requests in order after a random
//   latency with a word derived from the address.
module tb_if_fetch_unit;

  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fetch_en;
  logic        pc_src;
  logic [31:0] new_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        id_ready;

  if_fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .fetch_en    (fetch_en),
    .pc_src      (pc_src),
    .new_pc      (new_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .id_ready    (id_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  // Reference model
  int          m_st;        // 0 boot, 1 run, 2 stop
  logic [31:0] m_fpc;
  logic [31:0] m_rpc;
  ent_t        m_fifo[$];
  bit          m_out[$];    // one entry per in-flight request: 1 = wrong path
  pend_t       pend[$];     // bench memory: in-flight requests with due cycle

  // Stimulus knobs
  int unsigned pct_fe, pct_src, pct_idr, pct_mrdy;
  int unsigned lat_min, lat_max;
  bit          src_once;
  bit          src_need_rv;
  logic [31:0] forced_pc;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h1234};
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(3) == 0) r = 32'hFFFF_FFF0 | (r & 32'hF);
    return r;
  endfunction

  task automatic model_reset();
    m_st  = 0;
    m_fpc = RST_PC;
    m_rpc = RST_PC;
    m_fifo.delete();
    m_out.delete();
    pend.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"},   {31'b0, imem_req}, 32'h0);
    check({tag, "_addr"},  imem_addr,         RST_PC);
    check({tag, "_valid"}, {31'b0, if_valid}, 32'h0);
    check({tag, "_inst"},  if_inst,           32'h0);
    check({tag, "_pc"},    if_pc,             32'h0);
  endtask

  task automatic step();
    bit          rv, src, dropped, exp_req, exp_valid;
    logic [31:0] raddr;
    int          lat, due;
    ent_t        e;
    @(negedge clk);
    cyc++;
    fetch_en   = ($urandom_range(99) < pct_fe);
    id_ready   = ($urandom_range(99) < pct_idr);
    imem_ready = ($urandom_range(99) < pct_mrdy);
    rv    = (pend.size() > 0) && (pend[0].due <= cyc);
    raddr = rv ? pend[0].addr : 32'h0;
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(raddr) : $urandom;
    src    = 1'b0;
    new_pc = $urandom;
    if (src_once) begin
      if (!src_need_rv || (rv && (m_fifo.size() > 0) && id_ready)) begin
        src      = 1'b1;
        new_pc   = forced_pc;
        src_once = 1'b0;
      end
    end else if ($urandom_range(99) < pct_src) begin
      src    = 1'b1;
      new_pc = rand_pc();
    end
    pc_src = src;
    #1;
    exp_req   = (m_st == 1) && !src && ((m_fifo.size() + m_out.size()) < DEPTH);
    exp_valid = (m_fifo.size() > 0) && !src;
    check("imem_req",  {31'b0, imem_req}, {31'b0, exp_req});
    check("imem_addr", imem_addr,         m_fpc);
    check("if_valid",  {31'b0, if_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      check("if_inst", if_inst, m_fifo[0].inst);
      check("if_pc",   if_pc,   m_fifo[0].pc);
    end
    // Advance the model to the state after the coming edge.
    dropped = 1'b1;
    if (rv) begin
      dropped = m_out[0] || src;
      void'(m_out.pop_front());
      void'(pend.pop_front());
    end
    if (exp_valid && id_ready) void'(m_fifo.pop_front());
    if (rv && !dropped) begin
      e.inst = mem_word(raddr);
      e.pc   = m_rpc;
      m_fifo.push_back(e);
      m_rpc = m_rpc + 32'd4;
    end
    if (exp_req && imem_ready) begin
      lat = int'($urandom_range(lat_max, lat_min));
      due = cyc + lat;
      if (pend.size() > 0 && pend[pend.size()-1].due >= due) due = pend[pend.size()-1].due + 1;
      pend.push_back('{addr: m_fpc, due: due});
      m_out.push_back(1'b0);
      m_fpc = m_fpc + 32'd4;
    end
    if (src) begin
      m_fifo.delete();
      foreach (m_out[i]) m_out[i] = 1'b1;
      m_fpc = new_pc & 32'hFFFF_FFFC;
      m_rpc = m_fpc;
    end
    m_st = (m_st == 0) ? 1 : (fetch_en ? 1 : 2);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic knobs(input int unsigned fe, input int unsigned srcp, input int unsigned idr,
                       input int unsigned mrdy, input int unsigned lmin, input int unsigned lmax);
    pct_fe = fe; pct_src = srcp; pct_idr = idr; pct_mrdy = mrdy;
    lat_min = lmin; lat_max = lmax;
  endtask

  task automatic force_redirect(input logic [31:0] pc, input bit need_rv);
    forced_pc   = pc;
    src_need_rv = need_rv;
    src_once    = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; fetch_en = 1'b0; pc_src = 1'b0; new_pc = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    src_once = 1'b0; src_need_rv = 1'b0; forced_pc = '0;
    knobs(100, 0, 100, 100, 1, 1);
    model_reset();

    // Reset held three cycles, then boot and straight-line fetch
    repeat (3) @(posedge clk);
    #1 check_reset("reset");
    #1 rstn = 1'b1;
    run(20);

    // Backpressure: ID stalls, then single pops
    knobs(100, 0, 0, 100, 1, 1);
    run(10);
    knobs(100, 0, 100, 100, 1, 1);
    run(1);
    knobs(100, 0, 0, 100, 1, 1);
    run(6);
    knobs(100, 0, 100, 100, 1, 2);
    run(8);

    // Redirect with requests in flight
    knobs(100, 0, 100, 100, 3, 3);
    run(10);
    force_redirect(32'h0000_0100, 1'b0);
    run(20);

    // Redirect coincident with a response and a pop; unaligned target
    knobs(100, 0, 100, 100, 1, 1);
    force_redirect(32'h0000_0203, 1'b1);
    run(30);
    check("coincident_redirect", {31'b0, src_once}, 32'h0);

    // Address wrap at the top of memory
    knobs(100, 0, 100, 100, 1, 2);
    force_redirect(32'hFFFF_FFF8, 1'b0);
    run(20);

    // Asynchronous reset in the middle of traffic
    knobs(90, 3, 70, 80, 2, 4);
    run(200);
    @(negedge clk);
    #2 rstn = 1'b0;
    imem_rvalid = 1'b0; pc_src = 1'b0;
    #1 check_reset("async_reset");
    model_reset();
    @(posedge clk);
    #2 rstn = 1'b1;
    knobs(100, 0, 100, 100, 1, 3);
    run(20);

    // Long mixed random run
    knobs(85, 5, 70, 75, 1, 4);
    run(3000);
    knobs(30, 10, 40, 50, 1, 4);
    run(1500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
